// File: rtl/ardp_pkg.sv
// Shared types for the AR/BR/CR datapath sequencer: FSM states, op encoding, index-width helpers.
package ardp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_MUL  = 2'd1,
        OP_DIV  = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Index width never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/ardp_seq_arbiter_rr_arbiter.sv
// Round-robin picker: combinational grant from req and pointer; pointer advances past each winner.
module rr_arbiter
    import ardp_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_i,
    input  logic                        adv_i,
    output logic [N_REQ-1:0]            gnt_c,
    output logic [idx_w(N_REQ)-1:0]     idx_c,
    output logic                        any_c
);

    localparam int unsigned IW = idx_w(N_REQ);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Scan from the farthest offset down so the requester nearest the pointer wins.
    always_comb begin
        int pos;
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        pos   = 0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            pos = int'(ptr_q) + k;
            if (pos >= int'(N_REQ)) begin
                pos = pos - int'(N_REQ);
            end
            if (req_i[pos]) begin
                gnt_c      = '0;
                gnt_c[pos] = 1'b1;
                idx_c      = IW'(pos);
                any_c      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && any_c) begin
            ptr_d = (idx_c == IW'(N_REQ - 1)) ? '0 : idx_c + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ardp_seq_arbiter.sv
// Shares one AR/BR/CR datapath among N_REQ requesters; each job runs LOAD -> EXEC -> RESP.
module ardp_seq_arbiter
    import ardp_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned DW    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DW-1:0]         req_ar,
    input  logic [N_REQ*DW-1:0]         req_br,
    output logic [N_REQ-1:0]            gnt,
    output logic                        done,
    output logic [idx_w(N_REQ)-1:0]     done_id,
    output logic [DW-1:0]               result,
    output logic [DW-1:0]               dp_data_ar,
    output logic [DW-1:0]               dp_data_br,
    output logic                        Ld_AR_BR,
    output logic                        Div_AR_x2_CR,
    output logic                        Mul_BR_x2_CR,
    output logic                        Clr_CR,
    input  logic                        AR_gt_0,
    input  logic                        AR_lt_0,
    input  logic [DW-1:0]               dp_cr
);

    localparam int unsigned IW = idx_w(N_REQ);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              done_q, done_d;
    logic [IW-1:0]     done_id_q, done_id_d;
    logic [DW-1:0]     result_q, result_d;
    logic [DW-1:0]     ar_q, ar_d;
    logic [DW-1:0]     br_q, br_d;
    logic              ld_q, ld_d;
    logic              mul_q, mul_d;
    logic              div_q, div_d;
    logic              clr_q, clr_d;
    op_e               op_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic              arb_adv;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .clk   (clk),
        .reset (reset),
        .req_i (req),
        .adv_i (arb_adv),
        .gnt_c (arb_gnt),
        .idx_c (arb_idx),
        .any_c (arb_any)
    );

    // Next state plus next value of every registered output; strobes are one-cycle by default.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        ar_d      = ar_q;
        br_d      = br_q;
        ld_d      = 1'b0;
        op_d      = OP_NONE;
        arb_adv   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    arb_adv   = 1'b1;
                    gnt_d     = arb_gnt;
                    done_id_d = arb_idx;
                    ar_d      = req_ar[int'(arb_idx)*DW +: DW];
                    br_d      = req_br[int'(arb_idx)*DW +: DW];
                    ld_d      = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                // Flags settled at the LOAD negedge; Mul wins if both are ever high.
                if (AR_gt_0) begin
                    op_d = OP_MUL;
                end else if (AR_lt_0) begin
                    op_d = OP_DIV;
                end else begin
                    op_d = OP_CLR;
                end
                state_d = EXEC;
            end
            EXEC: begin
                result_d = dp_cr;
                done_d   = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        mul_d = (op_d == OP_MUL);
        div_d = (op_d == OP_DIV);
        clr_d = (op_d == OP_CLR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            result_q  <= '0;
            ar_q      <= '0;
            br_q      <= '0;
            ld_q      <= 1'b0;
            mul_q     <= 1'b0;
            div_q     <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            ar_q      <= ar_d;
            br_q      <= br_d;
            ld_q      <= ld_d;
            mul_q     <= mul_d;
            div_q     <= div_d;
            clr_q     <= clr_d;
        end
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign done_id      = done_id_q;
    assign result       = result_q;
    assign dp_data_ar   = ar_q;
    assign dp_data_br   = br_q;
    assign Ld_AR_BR     = ld_q;
    assign Mul_BR_x2_CR = mul_q;
    assign Div_AR_x2_CR = div_q;
    assign Clr_CR       = clr_q;

endmodule

// File: tb/tb_ardp_seq_arbiter.sv
// Directed bench for ardp_seq_arbiter with a negedge AR/BR/CR datapath model.
module tb_ardp_seq_arbiter;

    localparam int unsigned N_REQ = 2;
    localparam int unsigned DW    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_REQ-1:0]  req;
    logic [N_REQ*DW-1:0] req_ar;
    logic [N_REQ*DW-1:0] req_br;
    logic [N_REQ-1:0]  gnt;
    logic              done;
    logic [0:0]        done_id;
    logic [DW-1:0]     result;
    logic [DW-1:0]     dp_data_ar;
    logic [DW-1:0]     dp_data_br;
    logic              Ld_AR_BR;
    logic              Div_AR_x2_CR;
    logic              Mul_BR_x2_CR;
    logic              Clr_CR;
    logic              AR_gt_0;
    logic              AR_lt_0;
    logic [DW-1:0]     dp_cr;

    logic [DW-1:0]     m_ar = '0;
    logic [DW-1:0]     m_br = '0;
    logic [DW-1:0]     m_cr = '0;

    int checks = 0;
    int errors = 0;

    ardp_seq_arbiter #(.N_REQ(N_REQ), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_ar       (req_ar),
        .req_br       (req_br),
        .gnt          (gnt),
        .done         (done),
        .done_id      (done_id),
        .result       (result),
        .dp_data_ar   (dp_data_ar),
        .dp_data_br   (dp_data_br),
        .Ld_AR_BR     (Ld_AR_BR),
        .Div_AR_x2_CR (Div_AR_x2_CR),
        .Mul_BR_x2_CR (Mul_BR_x2_CR),
        .Clr_CR       (Clr_CR),
        .AR_gt_0      (AR_gt_0),
        .AR_lt_0      (AR_lt_0),
        .dp_cr        (dp_cr)
    );

    always #5 clk = ~clk;

    // Datapath acts on negedge.
    always @(negedge clk) begin
        if (Ld_AR_BR) begin
            m_ar <= dp_data_ar;
            m_br <= dp_data_br;
        end
        if (Mul_BR_x2_CR)      m_cr <= m_br << 1;
        else if (Div_AR_x2_CR) m_cr <= DW'($signed(m_ar) >>> 1);
        else if (Clr_CR)       m_cr <= '0;
    end

    assign AR_gt_0 = ($signed(m_ar) > 0);
    assign AR_lt_0 = ($signed(m_ar) < 0);
    assign dp_cr   = m_cr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Invariants sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("one_strobe", 32'($countones({Ld_AR_BR, Mul_BR_x2_CR, Div_AR_x2_CR, Clr_CR}) <= 1), 32'd1);
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("flags_excl", 32'(!(AR_gt_0 && AR_lt_0)), 32'd1);
            if (done) chk("no_strobe_resp", 32'({Ld_AR_BR, Mul_BR_x2_CR, Div_AR_x2_CR, Clr_CR}), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [DW-1:0] ar, input logic [DW-1:0] br);
        req_ar[i*DW +: DW] = ar;
        req_br[i*DW +: DW] = br;
    endtask

    // Called in an IDLE cycle with req already set; returns in the following IDLE cycle.
    // op: 1=Mul 2=Div 3=Clr. drop scrambles operands and drops req during LOAD.
    task automatic run_job(input int id, input int op, input logic [DW-1:0] exp_ar,
                           input logic [DW-1:0] exp_res, input bit drop);
        tick();
        chk("load_gnt", 32'(gnt), 32'(1 << id));
        chk("load_ld", 32'(Ld_AR_BR), 32'd1);
        chk("load_ar", 32'(dp_data_ar), 32'(exp_ar));
        chk("load_done", 32'(done), 32'd0);
        if (drop) begin
            set_ops(id, 16'd100, 16'd100);
            req = '0;
        end
        tick();
        chk("exec_ld", 32'(Ld_AR_BR), 32'd0);
        chk("exec_mul", 32'(Mul_BR_x2_CR), 32'(op == 1));
        chk("exec_div", 32'(Div_AR_x2_CR), 32'(op == 2));
        chk("exec_clr", 32'(Clr_CR), 32'(op == 3));
        chk("exec_ar_held", 32'(dp_data_ar), 32'(exp_ar));
        tick();
        chk("resp_done", 32'(done), 32'd1);
        chk("resp_id", 32'(done_id), 32'(id));
        chk("resp_gnt", 32'(gnt), 32'(1 << id));
        chk("resp_result", 32'(result), 32'(exp_res));
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_result_held", 32'(result), 32'(exp_res));
    endtask

    initial begin
        reset  = 1'b1;
        req    = 2'b11;
        req_ar = '0;
        req_br = '0;
        set_ops(0, 16'd5, 16'd7);
        set_ops(1, 16'd9, 16'd9);

        // Reset held with requests pending.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_strobes", 32'({Ld_AR_BR, Mul_BR_x2_CR, Div_AR_x2_CR, Clr_CR}), 32'd0);
            chk("rst_result", 32'(result), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
        end
        req   = 2'b00;
        reset = 1'b0;
        tick();
        chk("idle_no_req", 32'(gnt), 32'd0);

        // Single job, AR>0 -> Mul: 7*2.
        req = 2'b01;
        run_job(0, 1, 16'd5, 16'd14, 1'b0);
        req = 2'b00;

        // AR<0 -> Div: -8/2, then AR=0 -> Clr.
        set_ops(1, 16'hFFF8, 16'd3);
        req = 2'b10;
        run_job(1, 2, 16'hFFF8, 16'hFFFC, 1'b0);
        set_ops(1, 16'd0, 16'd3);
        run_job(1, 3, 16'd0, 16'd0, 1'b0);
        req = 2'b00;

        // Continuous contention alternates 0,1,0,1.
        set_ops(0, 16'd3, 16'd1);
        set_ops(1, 16'hFFFE, 16'd0);
        req = 2'b11;
        for (int j = 0; j < 20; j++) begin
            if (j % 2 == 0) run_job(0, 1, 16'd3, 16'd2, 1'b0);
            else            run_job(1, 2, 16'hFFFE, 16'hFFFF, 1'b0);
        end
        req = 2'b00;

        // Reset during EXEC aborts the job and rewinds the pointer.
        set_ops(0, 16'd5, 16'd7);
        req = 2'b01;
        tick();
        chk("abort_load_gnt", 32'(gnt), 32'd1);
        tick();
        chk("abort_exec_mul", 32'(Mul_BR_x2_CR), 32'd1);
        reset = 1'b1;
        tick();
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_done_id", 32'(done_id), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_strobes", 32'({Ld_AR_BR, Mul_BR_x2_CR, Div_AR_x2_CR, Clr_CR}), 32'd0);
        chk("abort_dp_ar", 32'(dp_data_ar), 32'd0);
        chk("abort_dp_br", 32'(dp_data_br), 32'd0);
        reset = 1'b0;
        req   = 2'b11;
        run_job(0, 1, 16'd5, 16'd14, 1'b0);
        run_job(1, 2, 16'hFFFE, 16'hFFFF, 1'b0);
        req = 2'b00;

        // Operands changed and req dropped after grant: latched values still used.
        set_ops(0, 16'hFFFA, 16'd9);
        req = 2'b01;
        run_job(0, 2, 16'hFFFA, 16'hFFFD, 1'b1);
        tick();
        chk("post_drop_idle", 32'(gnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule
